fxp_requant_pipe: RTL
=====================

# fxp_requant_pipe

Multi-lane, pipelined fixed-point to signed-integer requantizer with selectable rounding and saturation. It converts signed Q(IN_W-FRAC_W).FRAC_W gradient/parameter values to OUT_W-bit signed integers for the gradient-clipping datapath. It replaces the single-lane combinational rounder with a parametrised block that adds:
- a valid/ready streaming interface,
- a runtime rounding mode,
- per-lane saturation flags,
- a saturation event counter.

## Interface
Parameters:
- IN_W, 16, input word width (signed two's complement).
- FRAC_W, 8, fractional bits of the input. Legal range: FRAC_W >= 1 and IN_W - FRAC_W >= OUT_W.
- OUT_W, 8, output integer width (signed).
- LANES, 4, parallel channels per beat.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  rounding mode, sampled with each accepted beat:
  - 00 = truncate (floor).
  - 01 = round half up (toward +inf).
  - 10 = round half to even.
  - 11 = treated as 00.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W].
- out_sat  out  LANES  per-lane flag: that lane was clamped in this beat.
- clr_count  in  1  synchronous clear of sat_count.
- sat_count  out  16  running count of clamped lane-samples; saturates at 0xFFFF.

## Operation
Pipeline structure:
- Two register stages. S1 holds per-lane rounded sums plus a valid bit. S2 drives out_data, out_sat and out_valid.
- Advance enable: en = !out_valid || out_ready.
- in_ready = en (combinational).
- When en: S1 loads (in_valid && in_ready, with the rounded data); S2 loads S1. When !en both stages hold.

Rounding, per lane, with x the input sign-extended to IN_W+1 bits:
- mode 00: k = 0.
- mode 01: k = 2^(FRAC_W-1).
- mode 10: k = 2^(FRAC_W-1) - 1 + x[FRAC_W].
- S1 stores s = x + k (IN_W+1 bits; cannot overflow).

Integer extraction and saturation, in S2:
- q = s >>> FRAC_W (arithmetic shift, IN_W+1-FRAC_W bits).
- If q > 2^(OUT_W-1)-1: output MAX = 2^(OUT_W-1)-1, out_sat[i] = 1.
- If q < -2^(OUT_W-1): output MIN = -2^(OUT_W-1), out_sat[i] = 1.
- Otherwise: output q[OUT_W-1:0], out_sat[i] = 0.

sat_count:
- On each S2 load of a valid beat, add popcount(new out_sat), clamped at 0xFFFF.
- clr_count has priority: the count becomes 0 and that cycle's increment is dropped.

Lanes are fully independent; mode applies to all lanes of a beat.

## Timing
Reset (rst_n low, asynchronous):
- All S1/S2 state, out_valid, out_data, out_sat and sat_count are 0.
- in_ready = 1 during and after reset.

Latency and throughput:
- Latency is 2 cycles from acceptance to out_valid when unstalled.
- Throughput is 1 beat/cycle.

Handshake rules:
- While out_valid && !out_ready: out_data and out_sat are stable, in_ready = 0, nothing is lost.
- A bubble in S1 propagates as out_valid = 0 one cycle later.
- Simultaneous out_ready and in_valid on a full pipe: output retires, S2 takes S1, and S1 takes the new beat in the same edge.
- Reset mid-stream discards all in-flight beats; no partial output.

mode is registered with the beat: a change in mode only affects beats accepted after the change.

## Test plan
All values use default parameters.
- **Reset:** assert rst_n low mid-stream with a full pipe -> out_valid = 0, sat_count = 0, in_ready = 1 immediately; previous beats never appear.
- **Rounding modes:** lanes {0x0180, 0x0280, 0xFE80, 0x0000}:
  - mode 00 -> {1, 2, -2, 0}.
  - mode 01 -> {2, 3, -1, 0}.
  - mode 10 -> {2, 2, -2, 0}.
  - out_sat = 0 for all; out_valid 2 cycles after acceptance.
- **Saturation, mode 01:** lanes {0x7F80, 0x7FFF, 0x8000, 0x807F} -> out_data {0x7F, 0x7F, 0x80, 0x80}, out_sat = 4'b0011, sat_count += 2. Same lanes in mode 00 -> {0x7F, 0x7F, 0x80, 0x80}, out_sat = 0.
- **Backpressure:** stream 10 beats with out_ready toggling pseudo-randomly -> all 10 beats emerge in order, unchanged while stalled; in_ready = 0 exactly when out_valid && !out_ready.
- **Counter:**
  - preload to 0xFFFE via saturating beats, send another beat with 4 clamped lanes -> sat_count = 0xFFFF.
  - assert clr_count on a cycle that also loads a clamped beat -> sat_count = 0.
- **Mode switch:** change mode every cycle across back-to-back beats of 0x0280 -> outputs follow the per-beat mode: 00 -> 2, 01 -> 3, 10 -> 2.

Source files
------------

// File: rtl/fxp_requant_pipe.sv
// fxp_requant_pipe: multi-lane pipelined fixed-point to signed-integer
// requantizer with runtime rounding mode, per-lane saturation and a
// saturating clamp-event counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode[1:0]             rounding mode captured with each accepted beat
//                         (00 floor, 01 half up, 10 half even, 11 floor)
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_data               LANES x IN_W signed Q(IN_W-FRAC_W).FRAC_W values
//   out_valid / out_ready output handshake
//   out_data              LANES x OUT_W signed integers
//   out_sat               per-lane clamp flag for the current output beat
//   clr_count             synchronous clear of sat_count (wins over increment)
//   sat_count[15:0]       saturating count of clamped lane-samples
module fxp_requant_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [LANES-1:0]         out_sat,
  input  logic                     clr_count,
  output logic [15:0]              sat_count
);

  localparam int unsigned SW = IN_W + 1;           // sign-extended sum width
  localparam int unsigned QW = IN_W + 1 - FRAC_W;  // integer part width
  localparam int unsigned PW = $clog2(LANES + 1);  // popcount width
  localparam int unsigned CW = 16;                 // counter width

  localparam logic [SW-1:0]        K_HALF = SW'(2 ** (FRAC_W - 1));
  localparam logic signed [QW-1:0] Q_MAX  = QW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [QW-1:0] Q_MIN  = ~Q_MAX;
  localparam logic [OUT_W-1:0]     O_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     O_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  logic                      w_en;
  logic [LANES-1:0][SW-1:0]  w_x;
  logic [LANES-1:0][SW-1:0]  w_k;
  logic [LANES-1:0][SW-1:0]  w_sum;
  logic [LANES*OUT_W-1:0]    w_odata;
  logic [LANES-1:0]          w_osat;
  logic [PW-1:0]             w_pop;
  logic [CW:0]               w_cnt_sum;
  logic [CW-1:0]             w_cnt_next;

  logic [LANES-1:0][SW-1:0]  r_s1_sum;
  logic                      r_s1_valid;
  logic                      r_out_valid;
  logic [LANES*OUT_W-1:0]    r_out_data;
  logic [LANES-1:0]          r_out_sat;
  logic [CW-1:0]             r_cnt;

  // Both stages advance together whenever the output slot can be vacated.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Rounding bias per lane; half-even adds one extra LSB only when the
  // integer part is odd, so exact halves settle on the even neighbour.
  always_comb begin
    w_x   = '0;
    w_k   = '0;
    w_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_x[i] = {in_data[i*IN_W + IN_W - 1], in_data[i*IN_W +: IN_W]};
      case (mode)
        2'b01:   w_k[i] = K_HALF;
        2'b10:   w_k[i] = K_HALF - SW'(1) + SW'(w_x[i][FRAC_W]);
        default: w_k[i] = '0;
      endcase
      w_sum[i] = w_x[i] + w_k[i];
    end
  end

  // Integer extraction and clamp of the S1 sums, feeding S2.
  always_comb begin
    w_odata = '0;
    w_osat  = '0;
    w_pop   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if ($signed(r_s1_sum[i][SW-1:FRAC_W]) > Q_MAX) begin
        w_odata[i*OUT_W +: OUT_W] = O_MAX;
        w_osat[i]                 = 1'b1;
      end else if ($signed(r_s1_sum[i][SW-1:FRAC_W]) < Q_MIN) begin
        w_odata[i*OUT_W +: OUT_W] = O_MIN;
        w_osat[i]                 = 1'b1;
      end else begin
        w_odata[i*OUT_W +: OUT_W] = r_s1_sum[i][FRAC_W +: OUT_W];
      end
      w_pop = w_pop + PW'(w_osat[i]);
    end
  end

  // Counter increment with clamp at all-ones.
  always_comb begin
    w_cnt_sum  = (CW+1)'(r_cnt) + (CW+1)'(w_pop);
    w_cnt_next = w_cnt_sum[CW] ? '1 : w_cnt_sum[CW-1:0];
  end

  // Stage 1: rounded sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum <= w_sum;
      end
    end
  end

  // Stage 2: clamped outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_odata;
        r_out_sat  <= w_osat;
      end
    end
  end

  // Clamp event counter; clear drops the same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= '0;
    end else if (w_en && r_s1_valid) begin
      r_cnt <= w_cnt_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_cnt;

endmodule
